// File: rtl/xorn_pipe_acc.sv
// xorn_pipe_acc: registered XOR / XNOR / running-XOR accumulator with a
// single-stage valid/ready output register. It is the building block for
// parity, scrambler and checksum datapaths.
//
// Parameters:
//   WIDTH - operand and result width in bits (>= 1)
//   CNT_W - width of the saturating accumulated-beat counter (>= 1)
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous reset, active-high
//   IN_VALID  in   operand beat valid
//   IN_READY  out  block can accept a beat this cycle
//   MODE      in   00 XOR, 01 XNOR, 10 ACC, 11 ACC_START (sampled with the beat)
//   A, B      in   operands
//   OUT_VALID out  Y/CNT hold a valid result
//   OUT_READY in   downstream accepts the result
//   Y         out  registered result
//   CNT       out  beats in the current accumulation, saturating
//   PAR       out  XOR-reduction of Y (only with XORN_PIPE_ACC_PARITY_EN)
//
// Optional feature: define XORN_PIPE_ACC_PARITY_EN to add the PAR output.
//
// Handshake: a beat transfers on an edge where IN_VALID && IN_READY; a
// result transfers on an edge where OUT_VALID && OUT_READY. IN_READY is
// !OUT_VALID || OUT_READY, so the register refills in the same cycle it
// drains and throughput is one beat per cycle while OUT_READY is high.
// Valid must not depend on ready; once a result is shown it stays stable
// until it is accepted.

module xorn_pipe_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] CNT
`ifdef XORN_PIPE_ACC_PARITY_EN
  ,
  output logic             PAR
`endif
);

  typedef enum logic [1:0] {
    MODE_XOR       = 2'b00,
    MODE_XNOR      = 2'b01,
    MODE_ACC       = 2'b10,
    MODE_ACC_START = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e            mode;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] y_next;
  logic [CNT_W-1:0] cnt_next;

  assign mode     = mode_e'(MODE);
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = OUT_VALID && OUT_READY;

  // Next values for a beat; only committed on an input transfer, so a
  // stalled beat never advances the accumulator.
  always_comb begin
    x        = A ^ B;
    y_next   = x;
    acc_next = acc;
    cnt_next = CNT;
    case (mode)
      MODE_XOR: begin
        y_next = x;
      end
      MODE_XNOR: begin
        y_next = ~x;
      end
      MODE_ACC: begin
        acc_next = acc ^ x;
        y_next   = acc ^ x;
        // Saturate: ACC/Y keep accumulating, the count stops at all-ones.
        cnt_next = (CNT == CNT_MAX) ? CNT : CNT + CNT_ONE;
      end
      MODE_ACC_START: begin
        acc_next = x;
        y_next   = x;
        cnt_next = CNT_ONE;
      end
      default: begin
        y_next = x;
      end
    endcase
  end

  // Reset wins over any handshake at the same edge and drops whatever
  // beat was in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      Y         <= '0;
      CNT       <= '0;
      acc       <= '0;
`ifdef XORN_PIPE_ACC_PARITY_EN
      PAR       <= 1'b0;
`endif
    end else if (in_xfer) begin
      // Also covers simultaneous drain + refill: new result replaces old.
      OUT_VALID <= 1'b1;
      Y         <= y_next;
      CNT       <= cnt_next;
      acc       <= acc_next;
`ifdef XORN_PIPE_ACC_PARITY_EN
      PAR       <= ^y_next;
`endif
    end else if (out_xfer) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/xorn_pipe_acc.md
Name: xorn_pipe_acc

Overview:
Parametrised, registered successor to the 2-input XOR cell. Computes a bitwise XOR or XNOR of two WIDTH-bit operands, or a running XOR accumulation across beats. Uses a single-stage valid/ready pipeline register with backpressure. Used as the building block for parity, scrambler and checksum datapaths above the cell layer.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, 4, width of the accumulated-beat counter (>=1)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
IN_VALID  input  1  operand beat valid
IN_READY  output  1  block can accept a beat this cycle
MODE  input  2  00 XOR, 01 XNOR, 10 ACC, 11 ACC_START; sampled with the beat
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OUT_VALID  output  1  Y/CNT hold a valid result
OUT_READY  input  1  downstream accepts the result
Y  output  WIDTH  registered result
CNT  output  CNT_W  number of beats in the current accumulation, saturating

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high. All state updates occur on the rising edge of CLK.
- Reset (RST=1 at an edge): OUT_VALID=0, Y=0, CNT=0, internal ACC=0. RST overrides any simultaneous handshake. A beat that is mid-flight or unconsumed is dropped.
- Transfer rules:
  - Input transfer occurs when IN_VALID && IN_READY at an edge.
  - Output transfer occurs when OUT_VALID && OUT_READY at an edge.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational from OUT_READY; there is no combinational path from IN_VALID, A, B or MODE to any output.
- Latency: the result appears one cycle after input transfer. Full throughput is 1 beat/cycle while OUT_READY=1.
- On input transfer, let X = A ^ B:
  - XOR: Y <= X; ACC and CNT unchanged.
  - XNOR: Y <= ~X; ACC and CNT unchanged.
  - ACC: ACC <= ACC ^ X; Y <= ACC ^ X; CNT <= CNT+1, saturating at 2^CNT_W-1.
  - ACC_START: ACC <= X; Y <= X; CNT <= 1.
- OUT_VALID update each edge:
  - Set to 1 on input transfer.
  - Else cleared to 0 on output transfer.
  - Else held.
- Simultaneous output and input transfer in the same cycle: the new result replaces the old one and OUT_VALID stays 1.
- Stall (OUT_VALID=1, OUT_READY=0): Y and CNT are held stable, IN_READY=0, and ACC does not advance.
- When OUT_VALID=0, Y and CNT keep their last values. Downstream must ignore them.
- XOR/XNOR beats interleaved with ACC beats leave the accumulation intact. CNT reported on an XOR/XNOR beat is the unchanged accumulation count.
- CNT saturation: when CNT = 2^CNT_W-1, further ACC beats still update ACC/Y, and CNT holds at that value.

Optional Feature:
Macro: XORN_PIPE_ACC_PARITY_EN.
- Defined: adds output port PAR (output, 1 bit), registered with Y. PAR equals the XOR-reduction of the value loaded into Y, updates on the same edge as Y, resets to 0, and is held during stall.
- Undefined: the PAR port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, MODE=00, A=0xA5, B=0x0F, OUT_READY=1 -> next cycle OUT_VALID=1, Y=0xAA, CNT=0. With the macro defined, PAR=0.
- MODE=01, A=0x3C, B=0x3C -> Y=0xFF, one cycle later. Back-to-back beats on consecutive cycles emit consecutive results with no bubbles.
- MODE=11 A=0x01 B=0x00, then MODE=10 A=0x02 B=0x00, then MODE=10 A=0x04 B=0x01 -> Y sequence 0x01, 0x03, 0x06; CNT sequence 1, 2, 3.
- Backpressure: hold OUT_READY=0 with OUT_VALID=1 and IN_VALID=1 for 3 cycles -> IN_READY=0, Y/CNT stable, ACC unchanged. Release -> pending beat accepted in the release cycle and its result appears next cycle.
- CNT_W=2: ACC_START then 5 ACC beats -> CNT = 1, 2, 3, 3, 3, 3, while Y keeps accumulating correctly.
- Assert RST during a stall with OUT_VALID=1 -> next cycle OUT_VALID=0, Y=0, CNT=0. A following ACC beat with X=0x55 yields Y=0x55, CNT=1.
